// File: rtl/serial_mag_comparator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_mag_comparator_if : handshake/data bundle for the serial comparator
// Rev 1.0
// ---------------------------------------------------------------------------
interface serial_mag_comparator_if;
  logic start;
  logic abort;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic result_valid;
  logic eq;
  logic neq;
  logic lt;
  logic gt;
  logic lte;
  logic gte;

  modport master (
    output start, abort, bit_valid, a_bit, b_bit,
    input  busy, done, result_valid, eq, neq, lt, gt, lte, gte
  );

  modport slave (
    input  start, abort, bit_valid, a_bit, b_bit,
    output busy, done, result_valid, eq, neq, lt, gt, lte, gte
  );
endinterface
`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_mag_comparator : MSB-first serial magnitude comparator of A vs B.
// Optional SERIAL_CMP_SIGNED_EN selects two's-complement operands. Rev 1.0
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_mag_comparator_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_UND = 2'd0,
    REL_LT  = 2'd1,
    REL_GT  = 2'd2,
    REL_EQ  = 2'd3
  } rel_t;

  state_t        state_q, state_d;
  rel_t          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rv_q, rv_d;
  logic [5:0]    flags_q, flags_d;   // {eq, neq, lt, gt, lte, gte}

  rel_t bit_rel;
  rel_t rel_after;
  rel_t rel_final;

  // Relation implied by the current bit pair alone.
  always_comb begin
    bit_rel = REL_UND;
    if (bus.a_bit != bus.b_bit) begin
      bit_rel = bus.a_bit ? REL_GT : REL_LT;
`ifdef SERIAL_CMP_SIGNED_EN
      if (cnt_q == '0) begin
        bit_rel = bus.a_bit ? REL_LT : REL_GT;
      end
`endif
    end
    rel_after = (rel_q == REL_UND) ? bit_rel : rel_q;
    rel_final = (rel_after == REL_UND) ? REL_EQ : rel_after;
  end

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rv_d    = rv_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rel_d   = REL_UND;
          rv_d    = 1'b0;
          flags_d = '0;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.bit_valid) begin
          cnt_d = cnt_q + CW'(1);
          rel_d = rel_after;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            rel_d   = rel_final;
            done_d  = 1'b1;
            rv_d    = 1'b1;
            flags_d = {rel_final == REL_EQ,
                       rel_final != REL_EQ,
                       rel_final == REL_LT,
                       rel_final == REL_GT,
                       rel_final != REL_GT,
                       rel_final != REL_LT};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rel_q   <= REL_UND;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      flags_q <= flags_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.eq           = flags_q[5];
  assign bus.neq          = flags_q[4];
  assign bus.lt           = flags_q[3];
  assign bus.gt           = flags_q[2];
  assign bus.lte          = flags_q[1];
  assign bus.gte          = flags_q[0];

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// Testbench for serial_mag_comparator: vector table, random runs against an
// arithmetic reference, and hand sequences for stall/abort/reset corners.
module tb_serial_mag_comparator;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_mag_comparator_if bus ();

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   exp;   // {eq, neq, lt, gt, lte, gte}
  } vec_t;

  localparam logic [5:0] F_EQ = 6'b100011;
  localparam logic [5:0] F_LT = 6'b011010;
  localparam logic [5:0] F_GT = 6'b010101;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {bus.eq, bus.neq, bus.lt, bus.gt, bus.lte, bus.gte};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.busy, bus.done, bus.result_valid, flags()};
  endfunction

  // Reference: plain integer comparison of the two operands.
  function automatic logic [5:0] model(input int unsigned a, input int unsigned b);
    longint sa = longint'(a);
    longint sb = longint'(b);
    logic e, l, g;
`ifdef SERIAL_CMP_SIGNED_EN
    if (sa >= (longint'(1) << (W - 1))) sa = sa - (longint'(1) << W);
    if (sb >= (longint'(1) << (W - 1))) sb = sb - (longint'(1) << W);
`endif
    e = (sa == sb);
    l = (sa < sb);
    g = (sa > sb);
    return {e, ~e, l, g, l | e, g | e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full comparison; optional stall before bit index stall_at, start held
  // high through SHIFT, and start asserted during DONE.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] exp, input int stall_at,
                         input int stall_len, input bit start_hold,
                         input bit start_in_done, input string name);
    int dones = 0;
    bus.start = 1'b1;
    tick();
    bus.start = start_hold;
    chk({name, " start busy/rv/flags"}, outs(), 9'b100_000000);
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) begin
        bus.bit_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk({name, " stall busy/done"}, {bus.busy, bus.done}, 2'b10);
        end
      end
      bus.bit_valid = 1'b1;
      bus.a_bit = a[W-1-i];
      bus.b_bit = b[W-1-i];
      tick();
      if (bus.done) dones++;
    end
    bus.bit_valid = 1'b0;
    bus.start = start_in_done;
    chk({name, " done pulse"}, {bus.busy, bus.done, bus.result_valid}, 3'b011);
    chk({name, " flags"}, flags(), exp);
    tick();
    bus.start = 1'b0;
    chk({name, " hold after done"}, outs(), {3'b001, exp});
    chk({name, " single done"}, dones, 1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    vecs[0] = '{a: 4'd5,  b: 4'd5, exp: F_EQ};
    vecs[1] = '{a: 4'd3,  b: 4'd7, exp: F_LT};
`ifdef SERIAL_CMP_SIGNED_EN
    vecs[2] = '{a: 4'd9,  b: 4'd2, exp: F_LT};
    vecs[3] = '{a: 4'd0,  b: 4'd15, exp: F_GT};
    vecs[4] = '{a: 4'd15, b: 4'd0, exp: F_LT};
    vecs[5] = '{a: 4'd8,  b: 4'd7, exp: F_LT};
`else
    vecs[2] = '{a: 4'd9,  b: 4'd2, exp: F_GT};
    vecs[3] = '{a: 4'd0,  b: 4'd15, exp: F_LT};
    vecs[4] = '{a: 4'd15, b: 4'd0, exp: F_GT};
    vecs[5] = '{a: 4'd8,  b: 4'd7, exp: F_GT};
`endif
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    repeat (2) tick();
    chk("reset outputs", outs(), 9'd0);
    rst_n = 1'b1;

    // Start on the very first edge after reset release.
    for (int i = 0; i < 6; i++)
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].exp, -1, 0, 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Stall of three cycles between bits 2 and 3.
    run_cmp(4'd4, 4'd6, model(4, 6), 2, 3, 1'b0, 1'b0, "stall");

    // start held through SHIFT and asserted in DONE must be ignored.
    run_cmp(4'd12, 4'd10, model(12, 10), -1, 0, 1'b1, 1'b1, "start_ignored");
    chk("start in DONE ignored", {bus.busy, bus.result_valid}, 2'b01);

    // bit_valid in IDLE is ignored.
    bus.bit_valid = 1'b1;
    bus.a_bit = 1'b1;
    repeat (3) tick();
    bus.bit_valid = 1'b0;
    bus.a_bit = 1'b0;
    chk("bit_valid in IDLE", outs(), {3'b001, model(12, 10)});

    // Abort after two bits (abort wins over bit_valid).
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = (i == 0);
      bus.b_bit = (i == 0);
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort outputs", {bus.busy, bus.done, bus.result_valid}, 3'b000);
    repeat (3) begin
      tick();
      chk("abort no done", {bus.busy, bus.done, bus.result_valid}, 3'b000);
    end
    bus.bit_valid = 1'b0;
    run_cmp(4'd8, 4'd8, F_EQ, -1, 0, 1'b0, 1'b0, "after_abort");

    // Asynchronous reset after three bits.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = 1'b1;
      bus.b_bit = 1'b0;
      tick();
    end
    bus.bit_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async reset outputs", outs(), 9'd0);
    tick();
    rst_n = 1'b1;
    run_cmp(4'd1, 4'd2, model(1, 2), -1, 0, 1'b0, 1'b0, "after_reset");

    // Random operands and stalls against the arithmetic reference.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = (n % 5 == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
      run_cmp(ra, rb, model(ra, rb), int'($urandom_range(0, W)),
              int'($urandom_range(0, 2)), 1'b0, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a comparison; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, which cancels the comparison in progress.
REQ-006 SHALL have port bit_valid, input, 1, which qualifies a_bit and b_bit.
REQ-007 SHALL have ports a_bit and b_bit, input, 1 each, carrying the serial operand bits MSB first.
REQ-008 SHALL have port busy, output, 1, high while in SHIFT.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when a result is committed.
REQ-010 SHALL have port result_valid, output, 1, high while the eq/neq/lt/gt/lte/gte flags hold a committed result.
REQ-011 SHALL have ports eq, neq, lt, gt, lte and gte, output, 1 each, the registered relation of A to B.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE; reset enters IDLE.
REQ-013 IDLE with start=1 SHALL go to SHIFT, clear the bit counter and set the internal relation to UNDECIDED.
REQ-014 SHIFT SHALL consume one bit pair per cycle with bit_valid=1; cycles with bit_valid=0 SHALL stall without changing state.
REQ-015 While UNDECIDED, the first differing pair SHALL decide the relation (unsigned): a_bit=1,b_bit=0 gives GT; a_bit=0,b_bit=1 gives LT.
REQ-016 Once the relation is decided, later bits SHALL still be counted but SHALL NOT change it.
REQ-017 When the WIDTH-th bit is accepted, the FSM SHALL go to DONE on the next edge; a relation still UNDECIDED then SHALL become EQ.
REQ-018 On entering DONE, all six flags SHALL be registered together, done=1 and result_valid=1, giving a latency of one cycle after the last accepted bit.
REQ-019 The flags SHALL obey neq=~eq, lte=lt|eq, gte=gt|eq, with exactly one of lt, eq, gt high.
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle; the flags and result_valid SHALL hold until the next start is accepted.
REQ-021 Accepting start SHALL clear result_valid and all flags in the same edge.
REQ-022 start during SHIFT or DONE SHALL be ignored, and bit_valid in IDLE or DONE SHALL be ignored.
REQ-023 abort in SHIFT SHALL return the FSM to IDLE, leave result_valid=0 and produce no done pulse; abort has priority over bit_valid in the same cycle.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one comparison.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result_valid=0, all six flags=0 and the bit counter=0, including mid-SHIFT.
REQ-026 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 With SERIAL_CMP_SIGNED_EN defined, operands SHALL be two's complement: a differing first bit (MSB) gives a_bit=1 as LT and b_bit=1 as GT; all other bits follow REQ-015.
REQ-028 Without SERIAL_CMP_SIGNED_EN, the comparison SHALL be unsigned for all bits, and the signed logic SHALL be absent.

Verification
REQ-029 WIDTH=4, A=5, B=5, bits continuous -> done on the cycle after bit 4; eq=1, neq=0, lt=0, gt=0, lte=1, gte=1.
REQ-030 A=3, B=7 -> lt=1, neq=1, lte=1, gt=0, gte=0; A=9, B=2 unsigned -> gt=1, gte=1.
REQ-031 A=9, B=2 with SERIAL_CMP_SIGNED_EN (-7 vs 2) -> lt=1, lte=1, gt=0.
REQ-032 A=4, B=6 with bit_valid low for 3 cycles between bits 2 and 3 -> lt=1; busy stays high during the stall; exactly one done pulse.
REQ-033 Abort after 2 bits of A=8, B=8 -> IDLE, no done, result_valid=0; a new start with 8, 8 -> eq=1.
REQ-034 rst_n low after 3 bits -> all outputs 0 at once; a start issued during SHIFT is ignored, as is bit_valid in IDLE.
